// File: rtl/countdown_pkg.sv
// Shared state encoding, BCD limits and BCD helper functions for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int BCD_DIGIT_MAX        = 9;
  localparam int MINSEC_MAX           = 59;
  localparam int HOURS_MAX            = 99;
  localparam int MS_MAX               = 999;
  localparam int TICKS_PER_MS_DEFAULT = 100000;

  localparam logic [3:0]  BCD_9   = 4'h9;
  localparam logic [7:0]  BCD_59  = 8'h59;
  localparam logic [11:0] BCD_999 = 12'h999;

  // Any nibble above 9 is forced to 9 so the result is always a legal BCD digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_9) ? BCD_9 : d;
  endfunction

  // Digit clamp first; minutes/seconds are then limited to 59. Valid BCD compares numerically.
  function automatic logic [7:0] clamp_bcd2(input logic [7:0] v, input logic is_minsec);
    logic [7:0] c;
    c = {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    if (is_minsec && (c > BCD_59)) c = BCD_59;
    return c;
  endfunction

  // Two-digit BCD decrement; zero wraps to the supplied value (borrow case).
  function automatic logic [7:0] dec_bcd2(input logic [7:0] v, input logic [7:0] wrap);
    logic [7:0] r;
    if (v == 8'h00)          r = wrap;
    else if (v[3:0] == 4'h0) r = {v[7:4] - 4'd1, BCD_9};
    else                     r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Three-digit BCD decrement; 000 wraps to 999.
  function automatic logic [11:0] dec_bcd3(input logic [11:0] v);
    logic [11:0] r;
    if (v == 12'h000)        r = BCD_999;
    else if (v[3:0] != 4'h0) r = {v[11:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'h0) r = {v[11:8], v[7:4] - 4'd1, BCD_9};
    else                     r = {v[11:8] - 4'd1, BCD_9, BCD_9};
    return r;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles and emits a one-cycle tick every TICKS_PER_MS of them.
module ms_tick_gen
  import countdown_pkg::*;
#(
  parameter int TICKS_PER_MS = TICKS_PER_MS_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] r_cnt;

  // The tick is combinational so the timer can act on it at the end of the same cycle.
  assign o_tick = i_en && (r_cnt == LAST);

  // Count enabled cycles, restart after each tick, hold while disabled, clear on reset/clear.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS.mmm BCD countdown timer with load, pause/run control, expiry pulse and latched alarm.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICKS_PER_MS = TICKS_PER_MS_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        Start_Stop,
  input  logic        load,
  input  logic [7:0]  Hours_i,
  input  logic [7:0]  Minutes_i,
  input  logic [7:0]  Seconds_i,
  output logic [11:0] milli_o,
  output logic [7:0]  Seconds_o,
  output logic [7:0]  Minutes_o,
  output logic [7:0]  Hours_o,
  output logic        expired_o,
  output logic        alarm_o
);

  state_t      r_state;
  logic [11:0] r_ms;
  logic [7:0]  r_sec;
  logic [7:0]  r_min;
  logic [7:0]  r_hr;
  logic        r_expired;
  logic        r_alarm;

  logic        w_run;
  logic        w_tick;
  logic [7:0]  w_pre_hr;
  logic [7:0]  w_pre_min;
  logic [7:0]  w_pre_sec;
  logic        w_pre_nonzero;
  logic        w_ms_borrow;
  logic        w_sec_borrow;
  logic        w_min_borrow;
  logic [11:0] w_ms_nxt;
  logic [7:0]  w_sec_nxt;
  logic [7:0]  w_min_nxt;
  logic [7:0]  w_hr_nxt;
  logic        w_nxt_zero;

  // Prescaler runs only while counting; a load restarts the millisecond phase.
  assign w_run = (r_state == ST_RUNNING);

  ms_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick (
    .i_clk (clk_in),
    .i_rst (reset),
    .i_en  (w_run),
    .i_clr (load),
    .o_tick(w_tick)
  );

  // Preset is sanitised before capture so the outputs are always valid BCD.
  assign w_pre_hr      = clamp_bcd2(Hours_i,   1'b0);
  assign w_pre_min     = clamp_bcd2(Minutes_i, 1'b1);
  assign w_pre_sec     = clamp_bcd2(Seconds_i, 1'b1);
  assign w_pre_nonzero = |{w_pre_hr, w_pre_min, w_pre_sec};

  // Borrow chain: ms -> seconds -> minutes -> hours, each field only moves when all lower fields are zero.
  assign w_ms_borrow  = (r_ms == 12'h000);
  assign w_sec_borrow = w_ms_borrow && (r_sec == 8'h00);
  assign w_min_borrow = w_sec_borrow && (r_min == 8'h00);

  assign w_ms_nxt  = dec_bcd3(r_ms);
  assign w_sec_nxt = w_ms_borrow  ? dec_bcd2(r_sec, BCD_59) : r_sec;
  assign w_min_nxt = w_sec_borrow ? dec_bcd2(r_min, BCD_59) : r_min;
  assign w_hr_nxt  = w_min_borrow ? dec_bcd2(r_hr, 8'h00)   : r_hr;
  assign w_nxt_zero = ~|{w_hr_nxt, w_min_nxt, w_sec_nxt, w_ms_nxt};

  // Control FSM with registered time value, expiry pulse and alarm; reset beats load beats tick.
  always_ff @(posedge clk_in) begin
    r_expired <= 1'b0;
    if (reset) begin
      r_state <= ST_IDLE;
      r_ms    <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hr    <= '0;
      r_alarm <= 1'b0;
    end else if (load) begin
      r_ms    <= '0;
      r_sec   <= w_pre_sec;
      r_min   <= w_pre_min;
      r_hr    <= w_pre_hr;
      r_alarm <= 1'b0;
      r_state <= w_pre_nonzero ? ST_PAUSED : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_PAUSED: begin
          if (Start_Stop) r_state <= ST_RUNNING;
        end
        ST_RUNNING: begin
          if (w_tick) begin
            r_ms  <= w_ms_nxt;
            r_sec <= w_sec_nxt;
            r_min <= w_min_nxt;
            r_hr  <= w_hr_nxt;
          end
          if (w_tick && w_nxt_zero) begin
            r_expired <= 1'b1;
            r_alarm   <= 1'b1;
            r_state   <= ST_EXPIRED;
          end else if (!Start_Stop) begin
            r_state <= ST_PAUSED;
          end
        end
        ST_EXPIRED: begin
          r_state <= ST_EXPIRED;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign milli_o   = r_ms;
  assign Seconds_o = r_sec;
  assign Minutes_o = r_min;
  assign Hours_o   = r_hr;
  assign expired_o = r_expired;
  assign alarm_o   = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 1-cycle millisecond prescaler.
module tb_countdown_timer;
  import countdown_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        Start_Stop;
  logic        load;
  logic [7:0]  Hours_i;
  logic [7:0]  Minutes_i;
  logic [7:0]  Seconds_i;
  logic [11:0] milli_o;
  logic [7:0]  Seconds_o;
  logic [7:0]  Minutes_o;
  logic [7:0]  Hours_o;
  logic        expired_o;
  logic        alarm_o;

  int n_chk  = 0;
  int n_fail = 0;

  countdown_timer #(.TICKS_PER_MS(1)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .Start_Stop(Start_Stop),
    .load      (load),
    .Hours_i   (Hours_i),
    .Minutes_i (Minutes_i),
    .Seconds_i (Seconds_i),
    .milli_o   (milli_o),
    .Seconds_o (Seconds_o),
    .Minutes_o (Minutes_o),
    .Hours_o   (Hours_o),
    .expired_o (expired_o),
    .alarm_o   (alarm_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] tv(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input logic [11:0] ms);
    return {h, m, s, ms};
  endfunction

  function automatic logic [35:0] cur();
    return {Hours_o, Minutes_o, Seconds_o, milli_o};
  endfunction

  task automatic nxt(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Hours_i = h; Minutes_i = m; Seconds_i = s; load = 1'b1;
  endtask

  initial begin
    reset = 1'b1; Start_Stop = 1'b0; load = 1'b0;
    Hours_i = 8'h00; Minutes_i = 8'h00; Seconds_i = 8'h00;
    nxt(2);
    chk("rst_val",   cur(), tv(8'h00, 8'h00, 8'h00, 12'h000));
    chk("rst_exp",   expired_o, 0);
    chk("rst_alarm", alarm_o, 0);
    chk("rst_state", dut.r_state, ST_IDLE);
    reset = 1'b0;

    // 00:00:01 run to expiry
    Start_Stop = 1'b1; preset(8'h00, 8'h00, 8'h01);
    nxt(1); load = 1'b0;
    chk("ld1_val",   cur(), tv(8'h00, 8'h00, 8'h01, 12'h000));
    chk("ld1_state", dut.r_state, ST_PAUSED);
    nxt(1);
    chk("arm_val",   cur(), tv(8'h00, 8'h00, 8'h01, 12'h000));
    chk("arm_state", dut.r_state, ST_RUNNING);
    nxt(1);
    chk("tick1_val", cur(), tv(8'h00, 8'h00, 8'h00, 12'h999));
    nxt(998);
    chk("t999_val",  cur(), tv(8'h00, 8'h00, 8'h00, 12'h001));
    chk("t999_exp",  expired_o, 0);
    nxt(1);
    chk("t1000_val", cur(), tv(8'h00, 8'h00, 8'h00, 12'h000));
    chk("t1000_exp", expired_o, 1);
    chk("t1000_alm", alarm_o, 1);
    chk("t1000_st",  dut.r_state, ST_EXPIRED);
    nxt(1);
    chk("post_exp",  expired_o, 0);
    chk("post_alm",  alarm_o, 1);
    Start_Stop = 1'b0; nxt(3); Start_Stop = 1'b1; nxt(3);
    chk("hold_val",  cur(), tv(8'h00, 8'h00, 8'h00, 12'h000));
    chk("hold_alm",  alarm_o, 1);
    chk("hold_st",   dut.r_state, ST_EXPIRED);

    // Zero load clears alarm and stays idle
    Start_Stop = 1'b0; preset(8'h00, 8'h00, 8'h00);
    nxt(1); load = 1'b0;
    chk("zld_alm",   alarm_o, 0);
    chk("zld_st",    dut.r_state, ST_IDLE);
    Start_Stop = 1'b1; nxt(3);
    chk("zld_st2",   dut.r_state, ST_IDLE);
    chk("zld_exp",   expired_o, 0);
    chk("zld_val",   cur(), tv(8'h00, 8'h00, 8'h00, 12'h000));

    // 01:00:00 one tick borrows through every field
    preset(8'h01, 8'h00, 8'h00);
    nxt(1); load = 1'b0;
    chk("hr_ld",     cur(), tv(8'h01, 8'h00, 8'h00, 12'h000));
    nxt(1); Start_Stop = 1'b0;
    nxt(1);
    chk("hr_tick",   cur(), tv(8'h00, 8'h59, 8'h59, 12'h999));
    nxt(2);
    chk("hr_hold",   cur(), tv(8'h00, 8'h59, 8'h59, 12'h999));
    chk("hr_st",     dut.r_state, ST_PAUSED);

    // 00:20:00 tens-digit borrow in minutes
    Start_Stop = 1'b1; preset(8'h00, 8'h20, 8'h00);
    nxt(1); load = 1'b0;
    nxt(1); Start_Stop = 1'b0;
    nxt(1);
    chk("mn_tick",   cur(), tv(8'h00, 8'h19, 8'h59, 12'h999));

    // 00:00:05, 10 ticks, pause 20 cycles, resume
    Start_Stop = 1'b1; preset(8'h00, 8'h00, 8'h05);
    nxt(1); load = 1'b0;
    chk("p_ld",      cur(), tv(8'h00, 8'h00, 8'h05, 12'h000));
    nxt(10);
    chk("p_9tk",     cur(), tv(8'h00, 8'h00, 8'h04, 12'h991));
    Start_Stop = 1'b0;
    nxt(1);
    chk("p_10tk",    cur(), tv(8'h00, 8'h00, 8'h04, 12'h990));
    nxt(19);
    chk("p_hold",    cur(), tv(8'h00, 8'h00, 8'h04, 12'h990));
    chk("p_st",      dut.r_state, ST_PAUSED);
    Start_Stop = 1'b1;
    nxt(1);
    chk("p_rearm",   cur(), tv(8'h00, 8'h00, 8'h04, 12'h990));
    nxt(1);
    chk("p_resume",  cur(), tv(8'h00, 8'h00, 8'h04, 12'h989));

    // Reset mid-run, then reset together with load
    nxt(5);
    reset = 1'b1;
    nxt(1);
    chk("rmid_val",  cur(), tv(8'h00, 8'h00, 8'h00, 12'h000));
    chk("rmid_st",   dut.r_state, ST_IDLE);
    chk("rmid_alm",  alarm_o, 0);
    preset(8'h00, 8'h00, 8'h09);
    nxt(1);
    chk("rld_val",   cur(), tv(8'h00, 8'h00, 8'h00, 12'h000));
    chk("rld_st",    dut.r_state, ST_IDLE);
    reset = 1'b0; load = 1'b0;

    // Preset clamping and zero load
    Start_Stop = 1'b0; preset(8'h00, 8'h75, 8'h9A);
    nxt(1);
    chk("clamp1",    cur(), tv(8'h00, 8'h59, 8'h59, 12'h000));
    preset(8'hAB, 8'h75, 8'h9A);
    nxt(1);
    chk("clamp2",    cur(), tv(8'h99, 8'h59, 8'h59, 12'h000));
    preset(8'h00, 8'h00, 8'h00);
    nxt(1); load = 1'b0;
    chk("zero_st",   dut.r_state, ST_IDLE);
    chk("zero_alm",  alarm_o, 0);

    // Load coinciding with a tick wins
    Start_Stop = 1'b1; preset(8'h00, 8'h00, 8'h03);
    nxt(1); load = 1'b0;
    nxt(3);
    chk("lt_run",    cur(), tv(8'h00, 8'h00, 8'h02, 12'h998));
    preset(8'h00, 8'h00, 8'h07);
    nxt(1); load = 1'b0;
    chk("lt_val",    cur(), tv(8'h00, 8'h00, 8'h07, 12'h000));
    chk("lt_st",     dut.r_state, ST_PAUSED);
    nxt(2);
    chk("lt_tick",   cur(), tv(8'h00, 8'h00, 8'h06, 12'h999));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
